// File: rtl/i2s_receiver.sv
// I2S receiver: recovers left-justified stereo frames from an asynchronous I2S stream.
// Latency: FrameData/Valid update one MasterCLK cycle after the sampled WS fall that ends a frame.
// Backpressure: Valid/Ready handshake; a frame completing while Valid && !Ready is dropped with an Overrun pulse.
//
// Ports:
//   MasterCLK, nReset      system clock, synchronous active-low reset
//   I2S_CLK/WS/DATA        asynchronous serial bit clock, word select (0 = left), data MSB first
//   Ready                  consumer accepts FrameData when high together with Valid
//   FrameData, Valid       {left, right} frame and its valid flag
//   Overrun, FrameErr      single-cycle pulses: dropped frame, slot length error
module i2s_receiver #(
  parameter int SLOT_BITS = 16
) (
  input  logic                   MasterCLK,
  input  logic                   nReset,
  input  logic                   I2S_CLK,
  input  logic                   I2S_WS,
  input  logic                   I2S_DATA,
  input  logic                   Ready,
  output logic [2*SLOT_BITS-1:0] FrameData,
  output logic                   Valid,
  output logic                   Overrun,
  output logic                   FrameErr
);

  localparam int CNT_W = $clog2(SLOT_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SLOT_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SLOT_BITS + 1);

  localparam logic [1:0] ST_SYNC  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  logic                 clk_s1, clk_s2, clk_s3;
  logic                 ws_s1, ws_s2;
  logic                 dat_s1, dat_s2;
  logic                 ws_prev;
  logic [1:0]           state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [SLOT_BITS-1:0] shift;
  logic [SLOT_BITS-1:0] left_hold;

  logic                 sck_rise;
  logic                 ws_fall;
  logic                 ws_rise;
  logic                 frame_done;
  logic [SLOT_BITS-1:0] shift_in;
  logic [SLOT_BITS-1:0] restart;

  // WS and data travel through the same two-flop depth as the bit clock, so
  // on sck_rise ws_s2/dat_s2 are the values present at that I2S_CLK rising edge.
  assign sck_rise   = clk_s2 & ~clk_s3;
  assign ws_fall    = sck_rise & ws_prev & ~ws_s2;
  assign ws_rise    = sck_rise & ~ws_prev & ws_s2;
  assign frame_done = ws_fall && (state == ST_RIGHT) && (bit_cnt == CNT_FULL);
  assign shift_in   = {shift[SLOT_BITS-2:0], dat_s2};
  // Left-justified: the bit sampled with the WS edge is already the new slot's MSB.
  assign restart    = {{(SLOT_BITS-1){1'b0}}, dat_s2};

  always_ff @(posedge MasterCLK) begin
    if (!nReset) begin
      clk_s1    <= 1'b0;
      clk_s2    <= 1'b0;
      clk_s3    <= 1'b0;
      ws_s1     <= 1'b0;
      ws_s2     <= 1'b0;
      dat_s1    <= 1'b0;
      dat_s2    <= 1'b0;
      ws_prev   <= 1'b1;
      state     <= ST_SYNC;
      bit_cnt   <= '0;
      shift     <= '0;
      left_hold <= '0;
      FrameData <= '0;
      Valid     <= 1'b0;
      Overrun   <= 1'b0;
      FrameErr  <= 1'b0;
    end else begin
      clk_s1   <= I2S_CLK;
      clk_s2   <= clk_s1;
      clk_s3   <= clk_s2;
      ws_s1    <= I2S_WS;
      ws_s2    <= ws_s1;
      dat_s1   <= I2S_DATA;
      dat_s2   <= dat_s1;
      Overrun  <= 1'b0;
      FrameErr <= 1'b0;

      if (sck_rise) begin
        ws_prev <= ws_s2;
        case (state)
          ST_SYNC: begin
            if (ws_fall) begin
              shift   <= restart;
              bit_cnt <= CNT_ONE;
              state   <= ST_LEFT;
            end
          end
          ST_LEFT: begin
            if (ws_rise) begin
              if (bit_cnt == CNT_FULL) begin
                left_hold <= shift;
                shift     <= restart;
                bit_cnt   <= CNT_ONE;
                state     <= ST_RIGHT;
              end else begin
                FrameErr <= 1'b1;
                state    <= ST_SYNC;
              end
            end else begin
              // Excess bits are dropped; the counter parks one past full so an
              // over-long slot still fails the length check.
              if (bit_cnt < CNT_FULL) shift <= shift_in;
              if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
            end
          end
          ST_RIGHT: begin
            if (ws_fall) begin
              // A bad right slot loses only this frame; the WS fall is still a
              // valid left-slot start, so no resync is needed.
              if (bit_cnt != CNT_FULL) FrameErr <= 1'b1;
              shift   <= restart;
              bit_cnt <= CNT_ONE;
              state   <= ST_LEFT;
            end else begin
              if (bit_cnt < CNT_FULL) shift <= shift_in;
              if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: state <= ST_SYNC;
        endcase
      end

      // Output holding register: a new frame may replace the held one only
      // when the held one is being consumed in this same cycle.
      if (frame_done) begin
        if (!Valid || Ready) begin
          FrameData <= {left_hold, shift};
          Valid     <= 1'b1;
        end else begin
          Overrun <= 1'b1;
        end
      end else if (Valid && Ready) begin
        Valid <= 1'b0;
      end
    end
  end

endmodule
